// File: rtl/multicore_dispatcher.sv
// Launches a masked group of cores, tracks start acks and completions, and times the run.
// Define DISPATCH_TIMEOUT_EN to enable the run watchdog (TIMEOUT_CYCLES); otherwise timeout is tied low.
module multicore_dispatcher #(
    parameter int CORE_COUNT     = 4,
    parameter int CNT_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  launch,
    input  logic [CORE_COUNT-1:0] coreMask,
    input  logic                  abort,
    input  logic [CORE_COUNT-1:0] coreReady,
    input  logic [CORE_COUNT-1:0] coreDone,
    output logic [CORE_COUNT-1:0] coreStart,
    output logic                  busy,
    output logic                  allDone,
    output logic [CORE_COUNT-1:0] doneMask,
    output logic [CNT_WIDTH-1:0]  cycleCount,
    output logic                  timeout
);

    typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

    generate
        if (CORE_COUNT < 1 || CORE_COUNT > 16 || CNT_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("multicore_dispatcher: unsupported parameter combination");
        end
    endgenerate

    state_t                state;
    logic [CORE_COUNT-1:0] mask_reg;
    logic [CORE_COUNT-1:0] ack_reg;
    logic [CORE_COUNT-1:0] done_reg;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  accept;
    logic                  finishing;
    logic [CORE_COUNT-1:0] ack_next;
    logic [CORE_COUNT-1:0] done_next;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    always_comb begin
        accept    = launch && (coreMask != '0) && ((coreReady & coreMask) == coreMask);
        // a selected core acknowledges start by dropping ready
        ack_next  = ack_reg | (mask_reg & ~coreReady);
        done_next = done_reg | (coreDone & mask_reg);
        finishing = (state == RUN) && (done_next == mask_reg);
        cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
    logic timeout_q;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            mask_reg <= '0;
            ack_reg  <= '0;
            done_reg <= '0;
            cnt      <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef DISPATCH_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        mask_reg <= coreMask;
                        ack_reg  <= '0;
                        done_reg <= '0;
                        cnt      <= '0;
                        state    <= START;
                    end
                end
                START, RUN: begin
                    if (abort) begin
                        // abort beats completion and watchdog; counter holds
                        done_reg <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt      <= cnt_inc;
                        done_reg <= done_next;
                        if (state == START) begin
                            ack_reg <= ack_next;
                            if (ack_next == mask_reg) state <= RUN;
                        end else if (finishing) begin
                            state <= FIN;
                        end
`ifdef DISPATCH_TIMEOUT_EN
                        // completion on the same edge wins over the watchdog
                        if (!finishing && cnt_inc >= TO_LIM) begin
                            state     <= IDLE;
                            timeout_q <= 1'b1;
                        end
`endif
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign coreStart  = (state == START) ? (mask_reg & ~ack_reg) : '0;
    assign busy       = (state == START) || (state == RUN);
    assign allDone    = (state == FIN);
    assign doneMask   = done_reg;
    assign cycleCount = cnt;
`ifdef DISPATCH_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_multicore_dispatcher.sv
// Directed self-checking bench for multicore_dispatcher (4 cores, watchdog limit 16 when enabled).
module tb_multicore_dispatcher;

    localparam int N = 4;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         launch = 1'b0;
    logic [N-1:0] coreMask = '0;
    logic         abort = 1'b0;
    logic [N-1:0] coreReady = '0;
    logic [N-1:0] coreDone = '0;
    logic [N-1:0] coreStart;
    logic         busy;
    logic         allDone;
    logic [N-1:0] doneMask;
    logic [W-1:0] cycleCount;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int timeout_seen = 0;
    int alldone_seen = 0;

    multicore_dispatcher #(.CORE_COUNT(N), .CNT_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstN(rstN), .launch(launch), .coreMask(coreMask), .abort(abort),
        .coreReady(coreReady), .coreDone(coreDone), .coreStart(coreStart), .busy(busy),
        .allDone(allDone), .doneMask(doneMask), .cycleCount(cycleCount), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout) timeout_seen++;
        if (allDone) alldone_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full-mask run; dones land on edges 10, 12, 15 and 20 after acceptance
    task automatic run1(input string pfx);
        int ad;
        coreMask = 4'hF; coreReady = 4'hF; launch = 1'b1;
        tick();
        launch = 1'b0;
        check({pfx, "_start"}, coreStart, 4'hF);
        check({pfx, "_busy"}, busy, 1);
        check({pfx, "_dm_clr"}, doneMask, 0);
        coreReady = 4'h0;
        tick();
        check({pfx, "_start_drop"}, coreStart, 0);
        check({pfx, "_cnt1"}, cycleCount, 1);
        ad = 0;
        for (int e = 2; e <= 20; e++) begin
            coreDone = (e == 10) ? 4'h1 : (e == 12) ? 4'h2 : (e == 15) ? 4'h4 : (e == 20) ? 4'h8 : 4'h0;
            tick();
            ad += allDone;
            if (e == 15) check({pfx, "_dm_partial"}, doneMask, 4'h7);
        end
        coreDone = 4'h0;
        check({pfx, "_alldone"}, allDone, 1);
        check({pfx, "_cnt20"}, cycleCount, 20);
        check({pfx, "_dm_full"}, doneMask, 4'hF);
        check({pfx, "_pulses"}, ad, 1);
        tick();
        check({pfx, "_ad_low"}, allDone, 0);
        check({pfx, "_idle"}, busy, 0);
        check({pfx, "_cnt_hold"}, cycleCount, 20);
        check({pfx, "_dm_hold"}, doneMask, 4'hF);
    endtask

    initial begin
        logic [N-1:0] unsel_start;
        int saw_to;

        // reset state
        #3;
        check("rst_busy", busy, 0);
        check("rst_start", coreStart, 0);
        check("rst_cnt", cycleCount, 0);
        check("rst_dm", doneMask, 0);
        check("rst_ad", allDone, 0);
        #9 rstN = 1'b1;
        tick();

        // 1: full launch with staggered completions
        run1("t1");

        // 2: partial mask, unselected cores stay quiet and their done is ignored
        coreMask = 4'h5; coreReady = 4'h5; launch = 1'b1;
        tick();
        launch = 1'b0;
        check("t2_start", coreStart, 4'h5);
        unsel_start = coreStart & 4'hA;
        coreReady = 4'h0;
        tick();
        unsel_start |= coreStart & 4'hA;
        coreDone = 4'hA;
        tick();
        unsel_start |= coreStart & 4'hA;
        check("t2_ignore_unsel", doneMask, 0);
        coreDone = 4'h1;
        tick();
        check("t2_dm0", doneMask, 4'h1);
        check("t2_no_ad", allDone, 0);
        coreDone = 4'h4;
        tick();
        coreDone = 4'h0;
        check("t2_alldone", allDone, 1);
        check("t2_dm", doneMask, 4'h5);
        check("t2_cnt", cycleCount, 4);
        check("t2_unsel_start", unsel_start, 0);
        tick();

        // 3: launch refused until every selected core is ready; zero mask refused
        coreMask = 4'h0; coreReady = 4'hF; launch = 1'b1;
        tick();
        check("t3_zero_mask", busy, 0);
        coreMask = 4'hF; coreReady = 4'hB;
        tick();
        check("t3_notready_busy", busy, 0);
        check("t3_notready_start", coreStart, 0);
        check("t3_dm_untouched", doneMask, 4'h5);
        tick();
        check("t3_still_idle", busy, 0);
        coreReady = 4'hF;
        tick();
        launch = 1'b0;
        check("t3_accept", busy, 1);
        check("t3_start", coreStart, 4'hF);
        check("t3_dm_clr", doneMask, 0);
        coreReady = 4'h3;
        tick();
        check("t3_partial_ack", coreStart, 4'h3);
        coreReady = 4'h0;
        tick();
        check("t3_run", coreStart, 0);
        coreDone = 4'hF;
        tick();
        coreDone = 4'h0;
        check("t3_alldone", allDone, 1);
        check("t3_cnt", cycleCount, 3);
        tick();

        // 4: abort in RUN, abort beats a simultaneous completion
        alldone_seen = 0;
        coreMask = 4'hF; coreReady = 4'hF; launch = 1'b1;
        tick();
        launch = 1'b0; coreReady = 4'h0;
        tick();
        coreDone = 4'h1;
        tick();
        check("t4_dm0", doneMask, 4'h1);
        coreDone = 4'hE; abort = 1'b1;
        tick();
        coreDone = 4'h0; abort = 1'b0;
        check("t4_idle", busy, 0);
        check("t4_ad", allDone, 0);
        check("t4_dm_clr", doneMask, 0);
        check("t4_cnt_hold", cycleCount, 2);
        tick();
        check("t4_no_pulse", alldone_seen, 0);
        run1("t4r");

        // 5: asynchronous reset mid-run
        coreMask = 4'hF; coreReady = 4'hF; launch = 1'b1;
        tick();
        launch = 1'b0; coreReady = 4'h0;
        tick();
        coreDone = 4'h1;
        tick();
        coreDone = 4'h0;
        #2 rstN = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_dm", doneMask, 0);
        check("t5_cnt", cycleCount, 0);
        check("t5_start", coreStart, 0);
        #2 rstN = 1'b1;
        tick();
        tick();
        check("t5_stay_idle", busy, 0);
        check("t5_stay_ad", allDone, 0);

`ifdef DISPATCH_TIMEOUT_EN
        // 6: watchdog with core 1 never finishing
        alldone_seen = 0;
        saw_to = 0;
        coreMask = 4'hF; coreReady = 4'hF; launch = 1'b1;
        tick();
        launch = 1'b0; coreReady = 4'h0;
        for (int e = 1; e <= 40 && saw_to == 0; e++) begin
            coreDone = (e == 3) ? 4'h1 : (e == 4) ? 4'h4 : (e == 5) ? 4'h8 : 4'h0;
            tick();
            if (timeout) begin
                saw_to = 1;
                check("t6_cnt", cycleCount, 16);
                check("t6_dm", doneMask, 4'hD);
                check("t6_idle", busy, 0);
            end
        end
        coreDone = 4'h0;
        check("t6_fired", saw_to, 1);
        tick();
        check("t6_one_cycle", timeout, 0);
        check("t6_no_alldone", alldone_seen, 0);
`else
        saw_to = 0;
        check("no_watchdog", timeout_seen + saw_to, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "time limit");
    end

endmodule
